serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor: computes diff = (a - b) mod 2^WIDTH and
//  borrow = (a < b). It is the inverse-direction companion of the team's
//  ripple adders. One full-subtractor cell is reused LSB-first over WIDTH
//  cycles, with a borrow flop. Valid/ready handshakes on the operand and
//  result sides. Sits in datapaths where area beats latency.
// PARAMETERS
//  WIDTH    8   operand/result width in bits; legal range 2..32
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous reset, active-low
//  start_valid  in   1      operands a/b valid
//  start_ready  out  1      block can accept operands
//  a            in   WIDTH  minuend, sampled only on the accept edge
//  b            in   WIDTH  subtrahend, sampled only on the accept edge
//  busy         out  1      high in SHIFT state
//  done_valid   out  1      diff/borrow valid
//  done_ready   in   1      consumer accepts result
//  diff         out  WIDTH  (a - b) mod 2^WIDTH
//  borrow       out  1      1 iff a < b (unsigned)
// BEHAVIOUR
//  - Reset: clk is the single clock; rst_n is synchronous and active-low.
//    On an edge with rst_n=0: state=IDLE, shift regs=0, borrow flop=0,
//    diff=0, borrow=0, done_valid=0, busy=0, bit counter=0.
//    start_ready = (state==IDLE) && rst_n, so it is 0 while rst_n is low.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: start_ready=1. On start_valid && start_ready, load A<=a, B<=b,
//      borrow flop<=0, cnt<=0, then go to SHIFT.
//    SHIFT: each edge processes bit i = A[0], B[0], br:
//      d = A[0]^B[0]^br
//      br' = (~A[0]&B[0]) | (~(A[0]^B[0])&br)
//      Shift A and B right; shift d into the MSB of the result reg; cnt++.
//      On the edge where cnt==WIDTH-1, go to DONE, set done_valid=1, and
//      drive diff=result and borrow=br'.
//    DONE: diff, borrow and done_valid are held stable until
//      done_valid && done_ready. On that edge: go to IDLE, done_valid<=0.
//  - Latency: done_valid first seen high exactly WIDTH cycles after the
//    accept edge. Throughput is one op per WIDTH+2 cycles at best; there is
//    no restart in the same cycle as the result handshake.
//  - diff/borrow keep their last value in IDLE. They change only on the
//    DONE-entry edge or on reset.
//  - start_valid while in SHIFT/DONE is ignored. a/b may change freely
//    after the accept edge.
//  - done_ready while not in DONE is ignored. done_ready held low stalls
//    indefinitely with outputs unchanged.
//  - Reset mid-SHIFT or mid-DONE: the operation is abandoned, with no
//    partial result or done_valid pulse. The next op after reset is exact.
//  - cnt width = $clog2(WIDTH). No wrap beyond WIDTH-1 is reachable.
// STRUCTURE
//  - Shared package/include: FSM state encodings (IDLE=2'd0, SHIFT=2'd1,
//    DONE=2'd2), the counter-width function, and the WIDTH range check.
//  - One sub-module: full_sub (combinational 1-bit full subtractor:
//    inputs x, y, bin; outputs d, bout), instantiated once.
//  - Top level holds the FSM, counter, A/B/result shift regs and the
//    borrow flop.
// TESTING (WIDTH=8)
//  1. a=0x5A, b=0x23 -> after 8 cycles: diff=0x37, borrow=0, done_valid=1.
//  2. a=0x00, b=0x01 -> diff=0xFF, borrow=1. Also a=0xFF, b=0xFF ->
//     diff=0x00, borrow=0.
//  3. done_ready low for 5 cycles after done_valid -> diff, borrow and
//     done_valid stable throughout. Raise done_ready -> IDLE next edge,
//     start_ready=1.
//  4. Pulse start_valid with a=0x10, b=0x01 during SHIFT of op
//     (0x80-0x7F) -> result is 0x01, borrow=0. The second op is not taken.
//  5. rst_n=0 for 1 cycle at SHIFT bit 3 -> done_valid never pulses.
//     start_ready=1 after release. Next op 0x03-0x05 -> diff=0xFE,
//     borrow=1.
//  6. 1000 random back-to-back ops vs reference model (a-b)&0xFF and
//     (a<b). Latency is always 8 cycles.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM encodings, counter sizing and the legal WIDTH range.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   function automatic int unsigned cnt_w(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

   function automatic bit width_ok(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: d = x - y - bin.
// Purely combinational; reused once per bit by the serial top.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per cycle.
// Valid/ready on operands and result; result held until consumed.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CW = cnt_w(WIDTH);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_subtractor: WIDTH out of range");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
   logic             br_q, br_d, borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cell_d, cell_bout;
   logic             accept, release_res, last_bit;

   full_sub u_full_sub (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign accept      = start_valid && start_ready;
   assign release_res = done_valid && done_ready;
   assign last_bit    = (state_q == S_SHIFT)
                     && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept)      state_d = S_SHIFT;
         S_SHIFT: if (last_bit)    state_d = S_DONE;
         S_DONE:  if (release_res) state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state_q == S_IDLE) && rst_n;
      busy        = (state_q == S_SHIFT);
      done_valid  = (state_q == S_DONE);
   end

   // Datapath: result shifts in from the MSB so it is aligned after WIDTH bits.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d   = a;
               b_d   = b;
               br_d  = 1'b0;
               cnt_d = '0;
            end
         end
         S_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {cell_d, res_q[WIDTH-1:1]};
            br_d  = cell_bout;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
               diff_d   = {cell_d, res_q[WIDTH-1:1]};
               borrow_d = cell_bout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor at WIDTH=8.
// Expected results queued at issue, popped when done_valid appears.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a, b;
   logic         busy;
   logic         done_valid;
   logic         done_ready;
   logic [W-1:0] diff;
   logic         borrow;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .diff        (diff),
      .borrow      (borrow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      start_valid = 1'b1;
      a = av;
      b = bv;
      while (!start_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 40), 1);
      @(posedge clk);
      #1;
      e.diff   = av - bv;
      e.borrow = (av < bv);
      e.acc    = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      start_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic collect(input int stall);
      int   n = 0;
      exp_t e;
      while (!done_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(n < 40), 1);
      if (exp_q.size() == 0) begin
         chk("queue_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      if (!done_valid) return;
      chk("latency", 32'(cyc - e.acc), W);
      chk("diff", 32'(diff), 32'(e.diff));
      chk("borrow", 32'(borrow), 32'(e.borrow));
      repeat (stall) begin
         @(negedge clk);
         chk("stall_valid", 32'(done_valid), 1);
         chk("stall_diff", 32'(diff), 32'(e.diff));
         chk("stall_borrow", 32'(borrow), 32'(e.borrow));
      end
      done_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", 32'(done_valid), 0);
      chk("release_ready", 32'(start_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      done_ready  = 1'b1;
      a           = '0;
      b           = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(start_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(done_valid), 0);
      chk("rst_diff", 32'(diff), 0);
      chk("rst_borrow", 32'(borrow), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(start_ready), 1);

      issue(8'h5A, 8'h23);
      chk("shift_busy", 32'(busy), 1);
      collect(0);
      issue(8'h00, 8'h01);
      collect(0);
      issue(8'hFF, 8'hFF);
      collect(0);
      chk("idle_hold_diff", 32'(diff), 32'h00);

      done_ready = 1'b0;
      issue(8'hC3, 8'h3C);
      collect(5);

      issue(8'h80, 8'h7F);
      repeat (2) @(negedge clk);
      start_valid = 1'b1;
      a = 8'h10;
      b = 8'h01;
      chk("shift_no_ready", 32'(start_ready), 0);
      @(negedge clk);
      start_valid = 1'b0;
      collect(0);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_valid || busy) seen = 1'b1;
      end
      chk("ignored_start", 32'(seen), 0);

      issue(8'hAA, 8'h11);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(start_ready), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_diff", 32'(diff), 0);
      rst_n = 1'b1;
      void'(exp_q.pop_front());
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_valid) seen = 1'b1;
      end
      chk("midrst_no_pulse", 32'(seen), 0);
      chk("midrst_ready_after", 32'(start_ready), 1);
      issue(8'h03, 8'h05);
      collect(0);

      for (int i = 0; i < 1000; i++) begin
         issue(W'($urandom), W'($urandom));
         collect(0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
